datamem_lsu: RTL and testbench

- Load/store initiator that drives the single-port data memory on behalf of a multi-lane core.
- Accepts one vector memory request (N_LANES addresses, one op type, a lane mask) and serialises it into one memory access per active lane.
- Gathers read data into a response vector and returns it to the core with a valid/ready handshake.
- Sits between the core's execute stage and datamem: its mem_* ports connect directly to datamem's MemWrite/Address/WriteData/ReadData.

---
 rtl/datamem_lsu.sv | 159 +++++++++++++++
 tb/tb_datamem_lsu.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/datamem_lsu.sv
// datamem_lsu: load/store initiator for the single-port data memory.
//
// A vector request (N_LANES addresses, one op, a lane mask) is taken in IDLE.
// It is then split into one memory access per active lane, in ascending lane
// order. Load data is gathered into resp_rdata. The result is returned with a
// valid/ready handshake.
//
// Optional build macro: DATAMEM_LSU_COALESCE_EN
//   Loads only: all pending lanes that share the selected address finish in
//   the same access cycle. Stores still run one lane per cycle.
//
// Ports:
//   clk, reset_n             clock (rising edge), asynchronous active-low reset
//   req_valid / req_ready    request handshake (req_ready high only in IDLE)
//   req_write                1 = store, 0 = load
//   req_mask                 per-lane enable
//   req_addr, req_wdata      packed per-lane address / store data
//   resp_valid / resp_ready  response handshake (resp_valid high only in DONE)
//   resp_rdata               gathered load data (0 for stores and masked lanes)
//   mem_write, mem_addr,     to datamem MemWrite / Address / WriteData
//   mem_wdata
//   mem_rdata                from datamem ReadData (combinational read)
module datamem_lsu #(
  parameter int N_LANES = 4,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [N_LANES-1:0]          req_mask,
  input  logic [N_LANES*ADDR_W-1:0]   req_addr,
  input  logic [N_LANES*DATA_W-1:0]   req_wdata,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [N_LANES*DATA_W-1:0]   resp_rdata,
  output logic                        mem_write,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                      state_reg, state_next;
  logic                        write_reg;
  logic [N_LANES-1:0]          pend_reg;
  logic [N_LANES*ADDR_W-1:0]   addr_reg;
  logic [N_LANES*DATA_W-1:0]   wdata_reg;
  logic [N_LANES*DATA_W-1:0]   rdata_reg;

  logic [N_LANES-1:0]          first_oh;   // lowest pending lane, one-hot
  logic [N_LANES-1:0]          hit;        // lanes completed this cycle
  logic [N_LANES-1:0]          pend_next;
  logic [ADDR_W-1:0]           sel_addr;
  logic [DATA_W-1:0]           sel_wdata;
  logic                        accept;

  localparam logic [N_LANES-1:0] ONE = {{(N_LANES-1){1'b0}}, 1'b1};

  assign accept    = (state_reg == IDLE) && req_valid;
  // x & -x isolates the lowest set bit.
  assign first_oh  = pend_reg & (~pend_reg + ONE);
  assign pend_next = pend_reg & ~hit;

  // Address/data of the lowest pending lane. Scanning downward lets the
  // lowest index win.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = N_LANES - 1; i >= 0; i--) begin
      if (pend_reg[i]) begin
        sel_addr  = addr_reg[i*ADDR_W +: ADDR_W];
        sel_wdata = wdata_reg[i*DATA_W +: DATA_W];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_LANES; gi++) begin : g_lane
`ifdef DATAMEM_LSU_COALESCE_EN
      // A load serves every pending lane that reads the same location.
      assign hit[gi] = write_reg ? first_oh[gi]
                     : (pend_reg[gi] && (addr_reg[gi*ADDR_W +: ADDR_W] == sel_addr));
`else
      assign hit[gi] = first_oh[gi];
`endif

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          rdata_reg[gi*DATA_W +: DATA_W] <= '0;
        end else if (accept) begin
          rdata_reg[gi*DATA_W +: DATA_W] <= '0;
        end else if ((state_reg == ACCESS) && hit[gi] && !write_reg) begin
          rdata_reg[gi*DATA_W +: DATA_W] <= mem_rdata;
        end
      end
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_valid) state_next = (req_mask != '0) ? ACCESS : DONE;
      ACCESS:  if (pend_next == '0) state_next = DONE;
      DONE:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs. The memory port is quiet outside ACCESS.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_reg)
      IDLE:   req_ready = 1'b1;
      ACCESS: begin
        mem_write = write_reg;
        mem_addr  = sel_addr;
        mem_wdata = write_reg ? sel_wdata : '0;
      end
      DONE:   resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Request registers. The pending mask is retired as lanes complete.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      write_reg <= 1'b0;
      pend_reg  <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else if (accept) begin
      write_reg <= req_write;
      pend_reg  <= req_mask;
      addr_reg  <= req_addr;
      wdata_reg <= req_wdata;
    end else if (state_reg == ACCESS) begin
      pend_reg  <= pend_next;
    end
  end

  assign resp_rdata = rdata_reg;

endmodule

// File: tb/tb_datamem_lsu.sv
module tb_datamem_lsu;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_write;
  logic [3:0]  req_mask;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic        mem_write;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  datamem_lsu #(.N_LANES(4), .DATA_W(8), .ADDR_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_mask(req_mask), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Data memory model. It has a combinational read and a synchronous write.
  // There is also a bench-side preload port.
  logic [7:0] mem [256];
  logic       tb_load = 1'b0;
  logic [7:0] tb_addr = '0, tb_data = '0;
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_write)    mem[mem_addr] <= mem_wdata;
    else if (tb_load) mem[tb_addr]  <= tb_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // The memory must never be written while idle or holding a response.
  always @(negedge clk) begin
    if (reset_n && (req_ready || resp_valid)) chk("wr_outside_access", {31'b0, mem_write}, 32'd0);
  end

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    tb_load = 1'b1; tb_addr = a; tb_data = d;
    @(negedge clk);
    tb_load = 1'b0;
  endtask

  // Access log from the last request. One entry is recorded per ACCESS-cycle negedge.
  logic [7:0] acc_addr [8];
  logic [7:0] acc_wdata [8];
  logic       acc_wr [8];
  int         n_acc;
  int         edges;

  // Present a request at a negedge and run until resp_valid. edges counts
  // rising edges, including the accepting one.
  task automatic do_req(input string tag, input logic w, input logic [3:0] m,
                        input logic [31:0] a, input logic [31:0] d);
    bit done = 0;
    req_write = w; req_mask = m; req_addr = a; req_wdata = d; req_valid = 1'b1;
    edges = 0; n_acc = 0;
    while (!done && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      req_valid = 1'b0;
      if (resp_valid) done = 1;
      else if (n_acc < 8) begin
        acc_addr[n_acc] = mem_addr; acc_wdata[n_acc] = mem_wdata; acc_wr[n_acc] = mem_write;
        n_acc++;
      end
    end
    if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);
    $display("req %s write=%0b mask=%b addr=%h wdata=%h -> edges=%0d accesses=%0d rdata=%h",
             tag, w, m, a, d, edges, n_acc, resp_rdata);
  endtask

  task automatic finish_resp(input string tag);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, "_resp_valid_drop"}, {31'b0, resp_valid}, 32'd0);
    chk({tag, "_req_ready_back"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_mask = '0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    @(negedge clk);
    // Reset values
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
    chk("rst_mem_addr", {24'b0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {24'b0, mem_wdata}, 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 256; i++) poke(i[7:0], 8'h00);
    for (int i = 0; i < 4; i++) poke(i[7:0], 8'hA0 + i[7:0]);
    poke(8'hFF, 8'h5A);

    // Test 1: full-mask load of addresses 0..3.
    do_req("load4", 1'b0, 4'b1111, 32'h03020100, 32'h0);
    chk("load4_edges", edges, 32'd5);
    chk("load4_n_acc", n_acc, 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("load4_addr%0d", i), {24'b0, acc_addr[i]}, i);
      chk($sformatf("load4_wr%0d", i), {31'b0, acc_wr[i]}, 32'd0);
    end
    chk("load4_rdata", resp_rdata, 32'hA3A2A1A0);
    finish_resp("load4");

    // Test 2: sparse store to lanes 0 and 2. Lanes 1 and 3 point at 0xFF and must stay untouched.
    do_req("store02", 1'b1, 4'b0101, 32'hFF09FF05, 32'hEE22EE11);
    chk("store02_edges", edges, 32'd3);
    chk("store02_n_acc", n_acc, 32'd2);
    chk("store02_acc0", {acc_wr[0], acc_addr[0], acc_wdata[0]}, {1'b1, 8'h05, 8'h11});
    chk("store02_acc1", {acc_wr[1], acc_addr[1], acc_wdata[1]}, {1'b1, 8'h09, 8'h22});
    chk("store02_rdata", resp_rdata, 32'd0);
    finish_resp("store02");
    chk("store02_mem5", {24'b0, mem[5]}, 32'h11);
    chk("store02_mem9", {24'b0, mem[9]}, 32'h22);
    chk("store02_memFF", {24'b0, mem[8'hFF]}, 32'h5A);
    chk("store02_mem6", {24'b0, mem[6]}, 32'h00);

    // Test 3: follow-up load. The response is held in DONE for 3 cycles while a new request is offered.
    do_req("load02", 1'b0, 4'b0101, 32'hFF09FF05, 32'h0);
    chk("load02_rdata", resp_rdata, 32'h00220011);
    req_write = 1'b1; req_mask = 4'b1111; req_addr = 32'h63626160; req_wdata = 32'h99999999;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_resp_valid", i), {31'b0, resp_valid}, 32'd1);
      chk($sformatf("hold%0d_rdata", i), resp_rdata, 32'h00220011);
      chk($sformatf("hold%0d_req_ready", i), {31'b0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    finish_resp("hold");
    @(negedge clk);
    chk("hold_ignored_mem60", {24'b0, mem[8'h60]}, 32'h00);

    // Test 4: empty mask.
    do_req("empty", 1'b0, 4'b0000, 32'h03020100, 32'h0);
    chk("empty_edges", edges, 32'd1);
    chk("empty_n_acc", n_acc, 32'd0);
    chk("empty_rdata", resp_rdata, 32'd0);
    finish_resp("empty");

    // Test 5: reset pulsed during the second access of a 4-lane store.
    req_write = 1'b1; req_mask = 4'b1111; req_addr = 32'h43424140; req_wdata = 32'hD3D2D1D0;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_mid_lane0", {mem_write, mem_addr, mem_wdata}, {1'b1, 8'h40, 8'hD0});
    @(negedge clk);
    chk("rst_mid_lane1", {mem_write, mem_addr, mem_wdata}, {1'b1, 8'h41, 8'hD1});
    reset_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {req_ready, resp_valid, mem_write, mem_addr, mem_wdata},
        {1'b1, 1'b0, 1'b0, 8'h00, 8'h00});
    chk("rst_mid_rdata", resp_rdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    chk("rst_mid_mem40", {24'b0, mem[8'h40]}, 32'hD0);
    chk("rst_mid_mem41", {24'b0, mem[8'h41]}, 32'h00);
    chk("rst_mid_mem43", {24'b0, mem[8'h43]}, 32'h00);
    do_req("post_rst", 1'b0, 4'b0011, 32'h00004140, 32'h0);
    chk("post_rst_edges", edges, 32'd3);
    chk("post_rst_rdata", resp_rdata, 32'h000000D0);
    finish_resp("post_rst");

    // Test 6: duplicate addresses in a load.
    poke(8'h03, 8'h33);
    poke(8'h07, 8'h77);
    do_req("dup", 1'b0, 4'b1111, 32'h07070303, 32'h0);
`ifdef DATAMEM_LSU_COALESCE_EN
    chk("dup_n_acc", n_acc, 32'd2);
    chk("dup_edges", edges, 32'd3);
    chk("dup_addr1", {24'b0, acc_addr[1]}, 32'h07);
`else
    chk("dup_n_acc", n_acc, 32'd4);
    chk("dup_edges", edges, 32'd5);
    chk("dup_addr1", {24'b0, acc_addr[1]}, 32'h03);
    chk("dup_addr2", {24'b0, acc_addr[2]}, 32'h07);
`endif
    chk("dup_rdata", resp_rdata, 32'h77773333);
    finish_resp("dup");

    // Test 7: duplicate-address store. The higher lane is written last and wins.
    do_req("dupst", 1'b1, 4'b0011, 32'h00002020, 32'h0000BBAA);
    chk("dupst_n_acc", n_acc, 32'd2);
    finish_resp("dupst");
    chk("dupst_mem20", {24'b0, mem[8'h20]}, 32'hBB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
